// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// ----------------
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES
// chunks of CW = WIDTH/STAGES bits. Each pipeline stage adds one chunk and
// hands its carry to the next stage. The result carries carry/overflow/zero
// flags and moves under a valid/ready handshake.
//
// Optional feature (compile-time macro):
//   ADDSUB_SAT_EN - when defined, a signed overflow clamps sum to the signed
//                   limit in the direction of operand a. The overflow flag
//                   still reports it, zero is taken from the clamped value,
//                   and carry_out stays raw. When undefined, sum is the plain
//                   wrapped result.
//
// Parameters:
//   WIDTH   operand/result width, must be divisible by STAGES
//   STAGES  number of register stages (1..8), also the latency in cycles
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat present
//   in_ready   out  beat accepted this cycle when in_valid is high
//   a, b       in   operands
//   sub        in   0 = a+b, 1 = a-b
//   out_valid  out  result beat present
//   out_ready  in   consumer takes the result this cycle
//   sum        out  result modulo 2^WIDTH (clamped if ADDSUB_SAT_EN)
//   carry_out  out  carry out of the MSB (for subtract, 1 = no borrow)
//   overflow   out  two's-complement signed overflow
//   zero       out  sum == 0

module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  // The intermediate register count is at least 1 so the arrays stay legal
  // when STAGES = 1. In that case only the output registers are used.
  localparam int PR   = (STAGES > 1) ? STAGES - 1 : 1;

  // Per-stage valid bits. The last bit is the output valid.
  logic [STAGES-1:0] vld;

  // Intermediate stage registers: operands (b already conditioned), the
  // partial sum built so far, and the carry into the next chunk.
  logic [WIDTH-1:0] st_a [PR];
  logic [WIDTH-1:0] st_b [PR];
  logic [WIDTH-1:0] st_s [PR];
  logic             st_c [PR];

  // Stage inputs and the values each stage produces.
  logic [WIDTH-1:0] in_a [STAGES];
  logic [WIDTH-1:0] in_b [STAGES];
  logic [WIDTH-1:0] in_s [STAGES];
  logic             in_c [STAGES];
  logic [WIDTH-1:0] nx_a [STAGES];
  logic [WIDTH-1:0] nx_b [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic [CW:0]      chunk [STAGES];

  logic             stall;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] fin_sum;
  logic             top_a;
  logic             top_b;
  logic             ovf_raw;

  // A stall freezes the whole pipeline, including empty stages. The upstream
  // handshake therefore depends combinationally on out_ready.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld[LAST];

  // Stage k adds chunk k of its operands plus the incoming carry. All other
  // bits pass through unchanged. Subtraction is a + ~b + 1, so stage 0 inverts
  // b and uses sub as the initial carry.
  always_comb begin
    in_a[0] = a;
    in_b[0] = sub ? ~b : b;
    in_s[0] = '0;
    in_c[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      in_a[k] = st_a[k-1];
      in_b[k] = st_b[k-1];
      in_s[k] = st_s[k-1];
      in_c[k] = st_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, in_a[k][k*CW +: CW]} + {1'b0, in_b[k][k*CW +: CW]}
               + {{CW{1'b0}}, in_c[k]};
      nx_a[k]  = in_a[k];
      nx_b[k]  = in_b[k];
      nx_s[k]  = in_s[k];
      nx_s[k][k*CW +: CW] = chunk[k][CW-1:0];
      nx_c[k]  = chunk[k][CW];
    end
  end

  // The final stage produces the complete sum and the flags. Overflow uses
  // the conditioned b, so one rule covers both add and subtract.
  assign raw_sum = nx_s[LAST];
  assign top_a   = nx_a[LAST][WIDTH-1];
  assign top_b   = nx_b[LAST][WIDTH-1];
  assign ovf_raw = (top_a == top_b) & (raw_sum[WIDTH-1] != top_a);

`ifdef ADDSUB_SAT_EN
  // Clamp toward the sign of a. On overflow this is the direction in which
  // the true result left the representable range.
  assign fin_sum = ovf_raw ? (top_a ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}})
                           : raw_sum;
`else
  assign fin_sum = raw_sum;
`endif

  // Pipeline registers. The stage registers hold while the pipeline is
  // stalled, so the output beat stays stable until it is taken. Reset clears
  // every stage, which drops any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      for (int k = 0; k < PR; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
        st_c[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        st_a[k] <= nx_a[k];
        st_b[k] <= nx_b[k];
        st_s[k] <= nx_s[k];
        st_c[k] <= nx_c[k];
      end
      sum       <= fin_sum;
      carry_out <= nx_c[LAST];
      overflow  <= ovf_raw;
      zero      <= ~|fin_sum;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
// -------------------
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=2).
// A queue-based arithmetic model predicts every result beat. Directed
// vectors with hand-computed results pin both the model and the DUT.
// Define ADDSUB_SAT_EN for both files to check the saturating build.

module tb_pipelined_addsub;

  localparam int W      = 32;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_push = 0;
  int n_pop  = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0] va [8] = '{32'h00000005, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                           32'h12345678, 32'h80000000, 32'hFFFF0000, 32'h0000FFFF};
  logic [W-1:0] vb [8] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000,
                           32'h0000FFFF, 32'h80000000, 32'h00010000, 32'h00000001};
  logic         vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  pipelined_addsub #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Arithmetic reference model. It works on the integer values of the
  // operands: the unsigned result gives sum and carry, and the signed
  // result gives overflow (a result outside the 32-bit signed range).
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s);
    exp_t   e;
    longint ux, uy, sx, sy, full, sr;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = $signed(x);
    sy = $signed(y);
    if (!s) begin
      full = ux + uy;
      e.c  = (full >= 64'sd4294967296);
      sr   = sx + sy;
    end else begin
      full = ux - uy;
      e.c  = (ux >= uy);
      sr   = sx - sy;
    end
    e.s = full[W-1:0];
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
    if (e.o) e.s = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    e.z = (e.s == '0);
    return e;
  endfunction

  // Single comparison point: counts every check and reports failures.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Compare process. At each falling edge, check any valid output against
  // the head of the model queue. Retire the head when the consumer takes it,
  // and queue a prediction for each accepted input beat. Reset empties the
  // queue because in-flight beats are discarded.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_valid", out_valid, 0);
        end else begin
          e = exp_q[0];
          checkOutput("model_sum",       sum,       e.s);
          checkOutput("model_carry_out", carry_out, e.c);
          checkOutput("model_overflow",  overflow,  e.o);
          checkOutput("model_zero",      zero,      e.z);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        n_push++;
      end
    end
  end

  // Present one beat and hold it until the DUT accepts it. Call this 1 ns
  // after a rising edge. It returns 1 ns after the accepting edge with
  // in_valid still high, so back-to-back calls leave no bubble.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s);
    logic acc;
    a        = x;
    b        = y;
    sub      = s;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", in_ready, 1);
  endtask

  // Send one isolated beat, measure its latency, and check the result
  // against hand-computed values.
  task automatic runSingle(input string name, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic s,
                           input logic [W-1:0] es, input logic ec,
                           input logic eo, input logic ez);
    int lat;
    applyStimulus(x, y, s);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, "_latency"},   lat,       STAGES);
    checkOutput({name, "_sum"},       sum,       es);
    checkOutput({name, "_carry_out"}, carry_out, ec);
    checkOutput({name, "_overflow"},  overflow,  eo);
    checkOutput({name, "_zero"},      zero,      ez);
  endtask

  // Wait for the model queue to drain, then confirm that exactly the
  // expected number of beats came out.
  task automatic drainAndCount(input string name, input int pop0, input int expect_n);
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
    checkOutput({name, "_beat_count"},  n_pop - pop0, expect_n);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int pop0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_sum",       sum,       0);
    checkOutput("reset_carry_out", carry_out, 0);
    checkOutput("reset_overflow",  overflow,  0);
    checkOutput("reset_zero",      zero,      0);
    checkOutput("reset_in_ready",  in_ready,  1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    runSingle("add_small", 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0);
    runSingle("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
    runSingle("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
`else
    runSingle("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
`endif
    runSingle("sub_borrow", 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    runSingle("sub_equal",  32'h00001234, 32'h00001234, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // Stream four beats back-to-back, stalling the consumer for 3 cycles
    // once the first result appears.
    repeat (STAGES + 1) @(posedge clk);
    #1;
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(va[i], vb[i], vs[i]);
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 40 && !out_valid; t++) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
          checkOutput("stall_hold_sum", sum, 32'h00000008);
          checkOutput("stall_hold_valid", out_valid, 1);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("unstall_in_ready", in_ready, 1);
      end
    join
    drainAndCount("stream_stall", pop0, 4);

    // Stream the remaining vectors while the consumer toggles out_ready.
    pop0 = n_pop;
    fork
      begin
        for (int i = 4; i < 8; i++) applyStimulus(va[i], vb[i], vs[i]);
        in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 12; t++) begin
          out_ready = (t % 3 != 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drainAndCount("stream_toggle", pop0, 4);

    // Reset with two beats in flight. Outputs must clear at once, and no
    // stale beat may appear afterwards.
    applyStimulus(32'h11111111, 32'h22222222, 1'b0);
    applyStimulus(32'h01010101, 32'h10101010, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_sum",       sum,       0);
    checkOutput("midreset_carry_out", carry_out, 0);
    checkOutput("midreset_overflow",  overflow,  0);
    checkOutput("midreset_zero",      zero,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    runSingle("post_reset", 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0);
    repeat (STAGES + 2) @(posedge clk);
    #1;
    checkOutput("post_reset_idle_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
